sa_bresp_channel: RTL and testbench

// - Slave-arbiter write-response (B) return path. It is the reverse of the slave-arbiter AW/AR address channel.
// - Accepts B beats from one slave. Decodes the originating master from the extended slave ID and strips that prefix.
// - Delivers each beat to the matching master dispatcher through a 2-entry full-throughput buffer.

---
 rtl/sa_bresp_channel_pkg.sv | 37 +++
 rtl/sa_bresp_channel_if.sv | 51 +++++
 rtl/sa_bresp_channel_skid_buf.sv | 92 +++++++++
 rtl/sa_bresp_channel.sv | 160 ++++++++++++++++
 tb/tb_sa_bresp_channel.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sa_bresp_channel_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg -- shared types and constants for the slave-arbiter B-response path.
//
// Contents:
//   SA_*                 default configuration (masters, ID/resp widths)
//   SA_BRESP_BUF_DEPTH   depth of the response return buffer (2)
//   sa_bresp_entry_t     one buffered beat: {mst_idx, mst_id, resp}
//   sa_mst_idx()         extracts the master-index prefix from a slave ID
//
// The entry struct and the helper are sized from the SA_* constants, so the
// blocks that use them keep their parameters at these defaults.
// ---------------------------------------------------------------------------
package sa_pkg;

  localparam int SA_MST_AMT         = 3;
  localparam int SA_OUTSTANDING_AMT = 8;
  localparam int SA_TRANS_MST_ID_W  = 5;
  localparam int SA_MST_ID_W        = $clog2(SA_MST_AMT);
  localparam int SA_TRANS_SLV_ID_W  = SA_TRANS_MST_ID_W + SA_MST_ID_W;
  localparam int SA_TRANS_WR_RESP_W = 2;

  localparam int SA_BRESP_BUF_DEPTH = 2;

  typedef struct packed {
    logic [SA_MST_ID_W-1:0]        mst_idx;
    logic [SA_TRANS_MST_ID_W-1:0]  mst_id;
    logic [SA_TRANS_WR_RESP_W-1:0] resp;
  } sa_bresp_entry_t;

  // The slave-side ID carries the originating master index in its MSBs.
  function automatic logic [SA_MST_ID_W-1:0] sa_mst_idx(
    input logic [SA_TRANS_SLV_ID_W-1:0] slv_id
  );
    return slv_id[SA_TRANS_SLV_ID_W-1 -: SA_MST_ID_W];
  endfunction

endpackage

// File: rtl/sa_bresp_channel_if.sv
// ---------------------------------------------------------------------------
// sa_bresp_channel_if -- bundle of every bus signal of sa_bresp_channel.
//
// Signals:
//   s_BID_i / s_BRESP_i / s_BVALID_i / s_BREADY_o   B channel from the slave
//   dsp_BREADY_i / dsp_BID_o / dsp_BRESP_o /
//   dsp_BVALID_o                                     B beats to master dispatchers
//   aw_hsk_i / aw_mst_id_i                           AW acceptance notification
//   err_bad_id_o / err_unexp_o                       single-cycle error pulses
//
// Modports:
//   slave  -- view of the response channel block itself
//   master -- view of the surrounding logic that drives its inputs
// ---------------------------------------------------------------------------
interface sa_bresp_channel_if
  import sa_pkg::*;
#(
  parameter int MST_AMT         = SA_MST_AMT,
  parameter int TRANS_MST_ID_W  = SA_TRANS_MST_ID_W,
  parameter int MST_ID_W        = $clog2(MST_AMT),
  parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
  parameter int TRANS_WR_RESP_W = SA_TRANS_WR_RESP_W
);

  logic [TRANS_SLV_ID_W-1:0]  s_BID_i;
  logic [TRANS_WR_RESP_W-1:0] s_BRESP_i;
  logic                       s_BVALID_i;
  logic                       s_BREADY_o;

  logic [MST_AMT-1:0]         dsp_BREADY_i;
  logic [TRANS_MST_ID_W-1:0]  dsp_BID_o;
  logic [TRANS_WR_RESP_W-1:0] dsp_BRESP_o;
  logic [MST_AMT-1:0]         dsp_BVALID_o;

  logic                       aw_hsk_i;
  logic [MST_ID_W-1:0]        aw_mst_id_i;

  logic                       err_bad_id_o;
  logic                       err_unexp_o;

  modport slave (
    input  s_BID_i, s_BRESP_i, s_BVALID_i, dsp_BREADY_i, aw_hsk_i, aw_mst_id_i,
    output s_BREADY_o, dsp_BID_o, dsp_BRESP_o, dsp_BVALID_o, err_bad_id_o, err_unexp_o
  );

  modport master (
    output s_BID_i, s_BRESP_i, s_BVALID_i, dsp_BREADY_i, aw_hsk_i, aw_mst_id_i,
    input  s_BREADY_o, dsp_BID_o, dsp_BRESP_o, dsp_BVALID_o, err_bad_id_o, err_unexp_o
  );

endinterface

// File: rtl/sa_bresp_channel_skid_buf.sv
// ---------------------------------------------------------------------------
// sa_resp_skid_buf -- small valid/ready FIFO for response return paths
// (B here, reusable for R).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data / in_valid  write side; a beat is taken when in_valid & in_ready
//   in_ready            registered: high whenever the FIFO is not full
//   out_data/out_valid  head entry, valid whenever the FIFO is not empty
//   out_ready           pops the head when out_valid & out_ready
//
// in_ready is a pure register view of the occupancy, so there is no
// combinational path from out_ready to in_ready; with DEPTH=2 that still
// sustains one beat per cycle because push and pop may share a cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sa_resp_skid_buf
  import sa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = SA_BRESP_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] memReg [DEPTH];
  logic [PTR_W-1:0] wrPtrReg;
  logic [PTR_W-1:0] rdPtrReg;
  logic [CNT_W-1:0] countReg;
  logic [CNT_W-1:0] countNext;
  logic             readyReg;
  logic             push;
  logic             pop;

  assign push      = in_valid && readyReg;
  assign pop       = out_valid && out_ready;
  assign out_valid = (countReg != '0);
  assign out_data  = memReg[rdPtrReg];
  assign in_ready  = readyReg;

  always_comb begin
    countNext = countReg;
    if (push && !pop) begin
      countNext = countReg + CNT_W'(1);
    end else if (pop && !push) begin
      countNext = countReg - CNT_W'(1);
    end
  end

  // Entries are cleared on reset so the head payload reads as zero
  // straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        memReg[i] <= '0;
      end
    end else if (push) begin
      memReg[wrPtrReg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
      readyReg <= 1'b0;
    end else begin
      if (push) begin
        wrPtrReg <= wrPtrReg + PTR_W'(1);
      end
      if (pop) begin
        rdPtrReg <= rdPtrReg + PTR_W'(1);
      end
      countReg <= countNext;
      // Ready follows next-cycle occupancy, which also gives the
      // "low in reset, high one cycle after release" behaviour.
      readyReg <= (countNext != CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/sa_bresp_channel.sv
// ---------------------------------------------------------------------------
// sa_bresp_channel -- slave-arbiter write-response (B) return path.
//
// Takes B beats from one slave, decodes the originating master from the
// index prefix of the extended slave BID, strips that prefix and returns the
// beat to the matching master dispatcher through a 2-entry buffer.
//
// Ports:
//   ACLK_i      clock
//   ARESETn_i   asynchronous active-low reset
//   bus         sa_bresp_channel_if.slave:
//                 s_B*            slave-side B channel (s_BREADY_o registered)
//                 dsp_BID/BRESP   shared payload bus toward all masters
//                 dsp_BVALID_o    one-hot valid selecting the destination master
//                 dsp_BREADY_i    per-master ready
//                 aw_hsk_i/aw_mst_id_i  AW acceptance (used by the checker)
//                 err_bad_id_o    pulse: beat carried an index >= MST_AMT
//                 err_unexp_o     pulse: B delivered with no outstanding AW
//
// Build option: define SA_BRESP_OUTSTANDING_CHECK_EN to add per-master
// outstanding-AW counters driving err_unexp_o. Without it the aw_* inputs are
// ignored and err_unexp_o is held at 0.
// ---------------------------------------------------------------------------
module sa_bresp_channel
  import sa_pkg::*;
#(
  parameter int MST_AMT         = SA_MST_AMT,
  parameter int OUTSTANDING_AMT = SA_OUTSTANDING_AMT,
  parameter int TRANS_MST_ID_W  = SA_TRANS_MST_ID_W,
  parameter int MST_ID_W        = $clog2(MST_AMT),
  parameter int TRANS_SLV_ID_W  = TRANS_MST_ID_W + MST_ID_W,
  parameter int TRANS_WR_RESP_W = SA_TRANS_WR_RESP_W
) (
  input logic               ACLK_i,
  input logic               ARESETn_i,
  sa_bresp_channel_if.slave bus
);

  localparam int ENTRY_W = $bits(sa_bresp_entry_t);

  sa_bresp_entry_t      inEntry;
  sa_bresp_entry_t      headEntry;
  logic [ENTRY_W-1:0]   headVec;
  logic [MST_ID_W-1:0]  slvIdx;
  logic                 idxOk;
  logic                 accept;
  logic                 bufInValid;
  logic                 bufInReady;
  logic                 headValid;
  logic [MST_AMT-1:0]   dspValid;
  logic                 dspHsk;
  logic                 errBadIdReg;

  // ---------------- ID decode and bad-ID filter ----------------
  assign slvIdx = sa_mst_idx(bus.s_BID_i);
  assign idxOk  = (int'(slvIdx) < MST_AMT);

  assign inEntry.mst_idx = slvIdx;
  assign inEntry.mst_id  = bus.s_BID_i[TRANS_MST_ID_W-1:0];
  assign inEntry.resp    = bus.s_BRESP_i;

  // A bad-index beat is still handshaken with the slave (it must not block
  // the channel), it is simply never written into the buffer.
  assign accept     = bus.s_BVALID_i && bufInReady;
  assign bufInValid = bus.s_BVALID_i && idxOk;

  sa_resp_skid_buf #(
    .WIDTH (ENTRY_W),
    .DEPTH (SA_BRESP_BUF_DEPTH)
  ) u_buf (
    .clk       (ACLK_i),
    .rst_n     (ARESETn_i),
    .in_data   (inEntry),
    .in_valid  (bufInValid),
    .in_ready  (bufInReady),
    .out_data  (headVec),
    .out_valid (headValid),
    .out_ready (dspHsk)
  );

  assign headEntry = sa_bresp_entry_t'(headVec);

  // ---------------- one-hot valid toward the dispatchers ----------------
  genvar gi;
  generate
    for (gi = 0; gi < MST_AMT; gi++) begin : g_onehot
      assign dspValid[gi] = headValid && (int'(headEntry.mst_idx) == gi);
    end
  endgenerate

  // Only the addressed master's ready can complete the head beat, so a
  // stalled head holds back younger beats regardless of their destination.
  assign dspHsk = |(dspValid & bus.dsp_BREADY_i);

  assign bus.s_BREADY_o   = bufInReady;
  assign bus.dsp_BVALID_o = dspValid;
  assign bus.dsp_BID_o    = headEntry.mst_id;
  assign bus.dsp_BRESP_o  = headEntry.resp;

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      errBadIdReg <= 1'b0;
    end else begin
      errBadIdReg <= accept && !idxOk;
    end
  end

  assign bus.err_bad_id_o = errBadIdReg;

  // ---------------- optional outstanding-AW checker ----------------
`ifdef SA_BRESP_OUTSTANDING_CHECK_EN
  localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

  logic [MST_AMT-1:0] unexpHit;
  logic               errUnexpReg;

  generate
    for (gi = 0; gi < MST_AMT; gi++) begin : g_outstanding
      logic [CNT_W-1:0] outCntReg;
      logic             awInc;
      logic             bDec;

      assign awInc = bus.aw_hsk_i && (int'(bus.aw_mst_id_i) == gi);
      assign bDec  = dspHsk && dspValid[gi];

      // Delivered with nothing outstanding: flag it, the beat still goes out.
      assign unexpHit[gi] = bDec && (outCntReg == '0);

      always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
          outCntReg <= '0;
        end else if (awInc && !bDec) begin
          if (outCntReg < CNT_W'(OUTSTANDING_AMT)) begin
            outCntReg <= outCntReg + CNT_W'(1);
          end
        end else if (bDec && !awInc) begin
          if (outCntReg != '0) begin
            outCntReg <= outCntReg - CNT_W'(1);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      errUnexpReg <= 1'b0;
    end else begin
      errUnexpReg <= |unexpHit;
    end
  end

  assign bus.err_unexp_o = errUnexpReg;
`else
  logic unusedSink;
  assign unusedSink      = ^{bus.aw_hsk_i, bus.aw_mst_id_i, OUTSTANDING_AMT};
  assign bus.err_unexp_o = 1'b0;
`endif

endmodule

// File: tb/tb_sa_bresp_channel.sv
// ---------------------------------------------------------------------------
// tb_sa_bresp_channel -- directed self-checking bench for sa_bresp_channel
// (MST_AMT=3, TRANS_MST_ID_W=5, TRANS_SLV_ID_W=7). Inputs change and outputs
// are sampled on the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_sa_bresp_channel;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  sa_bresp_channel_if #(
    .MST_AMT         (3),
    .TRANS_MST_ID_W  (5),
    .TRANS_WR_RESP_W (2)
  ) bus ();

  sa_bresp_channel #(
    .MST_AMT         (3),
    .OUTSTANDING_AMT (8),
    .TRANS_MST_ID_W  (5),
    .TRANS_WR_RESP_W (2)
  ) dut (
    .ACLK_i    (clk),
    .ARESETn_i (rstn),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] idx, input logic [4:0] id, input logic [1:0] resp);
    bus.s_BID_i    = {idx, id};
    bus.s_BRESP_i  = resp;
    bus.s_BVALID_i = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] eIdx;
    logic [4:0] eId;
    logic [1:0] eResp;

    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    bus.s_BID_i      = '0;
    bus.s_BRESP_i    = '0;
    bus.s_BVALID_i   = 1'b0;
    bus.dsp_BREADY_i = '0;
    bus.aw_hsk_i     = 1'b0;
    bus.aw_mst_id_i  = '0;

    // ---- reset state ----
    repeat (3) tick();
    chk("rst_bready",  bus.s_BREADY_o,   1'b0);
    chk("rst_bvalid",  bus.dsp_BVALID_o, 3'b000);
    chk("rst_bid",     bus.dsp_BID_o,    5'd0);
    chk("rst_bresp",   bus.dsp_BRESP_o,  2'd0);
    chk("rst_badid",   bus.err_bad_id_o, 1'b0);
    chk("rst_unexp",   bus.err_unexp_o,  1'b0);
    rstn = 1'b1;
    tick();
    chk("rel_bready",  bus.s_BREADY_o,   1'b1);

    // ---- single beat to master 2 ----
    bus.dsp_BREADY_i = 3'b111;
    drive(2'b10, 5'b00101, 2'd0);
    tick();
    bus.s_BVALID_i = 1'b0;
    chk("t1_bvalid",   bus.dsp_BVALID_o, 3'b100);
    chk("t1_bid",      bus.dsp_BID_o,    5'd5);
    chk("t1_bresp",    bus.dsp_BRESP_o,  2'd0);
    tick();
    chk("t1_popped",   bus.dsp_BVALID_o, 3'b000);

    // ---- back-to-back to masters 0,1,2,0 ----
    for (int i = 0; i < 4; i++) begin
      eIdx  = 2'(i % 3);
      eId   = 5'(3 + 7 * i);
      eResp = 2'(i);
      drive(eIdx, eId, eResp);
      tick();
      chk("t2_bvalid", bus.dsp_BVALID_o, 3'b001 << eIdx);
      chk("t2_bid",    bus.dsp_BID_o,    eId);
      chk("t2_bresp",  bus.dsp_BRESP_o,  eResp);
      chk("t2_bready", bus.s_BREADY_o,   1'b1);
    end
    bus.s_BVALID_i = 1'b0;
    tick();
    chk("t2_drained",  bus.dsp_BVALID_o, 3'b000);

    // ---- backpressure: three beats offered, two fit ----
    bus.dsp_BREADY_i = 3'b000;
    drive(2'd1, 5'd6, 2'd1);
    tick();
    chk("t3_a_valid",  bus.dsp_BVALID_o, 3'b010);
    chk("t3_a_id",     bus.dsp_BID_o,    5'd6);
    drive(2'd0, 5'd9, 2'd2);
    tick();
    chk("t3_full_rdy", bus.s_BREADY_o,   1'b0);
    chk("t3_hold_v",   bus.dsp_BVALID_o, 3'b010);
    drive(2'd2, 5'd12, 2'd3);
    tick();
    chk("t3_stall_rdy", bus.s_BREADY_o,  1'b0);
    chk("t3_stall_id",  bus.dsp_BID_o,   5'd6);
    chk("t3_stall_rsp", bus.dsp_BRESP_o, 2'd1);
    bus.dsp_BREADY_i = 3'b111;
    tick();
    chk("t3_b_valid",  bus.dsp_BVALID_o, 3'b001);
    chk("t3_b_id",     bus.dsp_BID_o,    5'd9);
    chk("t3_b_rsp",    bus.dsp_BRESP_o,  2'd2);
    chk("t3_rdy_back", bus.s_BREADY_o,   1'b1);
    tick();
    bus.s_BVALID_i = 1'b0;
    chk("t3_c_valid",  bus.dsp_BVALID_o, 3'b100);
    chk("t3_c_id",     bus.dsp_BID_o,    5'd12);
    chk("t3_c_rsp",    bus.dsp_BRESP_o,  2'd3);
    tick();
    chk("t3_drained",  bus.dsp_BVALID_o, 3'b000);
    chk("t3_rdy_end",  bus.s_BREADY_o,   1'b1);

    // ---- bad master index ----
    drive(2'b11, 5'b00001, 2'd0);
    tick();
    chk("t4_badid",    bus.err_bad_id_o, 1'b1);
    chk("t4_novalid",  bus.dsp_BVALID_o, 3'b000);
    drive(2'd0, 5'd2, 2'd1);
    tick();
    bus.s_BVALID_i = 1'b0;
    chk("t4_badid_off", bus.err_bad_id_o, 1'b0);
    chk("t4_next_v",   bus.dsp_BVALID_o, 3'b001);
    chk("t4_next_id",  bus.dsp_BID_o,    5'd2);
    chk("t4_next_rsp", bus.dsp_BRESP_o,  2'd1);
    tick();
    chk("t4_drained",  bus.dsp_BVALID_o, 3'b000);
    chk("t4_badid_1x", bus.err_bad_id_o, 1'b0);

`ifdef SA_BRESP_OUTSTANDING_CHECK_EN
    // ---- outstanding checker: two AW, three B for master 1 ----
    tick();
    bus.aw_hsk_i    = 1'b1;
    bus.aw_mst_id_i = 2'd1;
    tick();
    tick();
    bus.aw_hsk_i = 1'b0;
    drive(2'd1, 5'd4, 2'd0);
    tick();
    tick();
    chk("t5_b1_unexp", bus.err_unexp_o, 1'b0);
    tick();
    bus.s_BVALID_i = 1'b0;
    chk("t5_b2_unexp", bus.err_unexp_o, 1'b0);
    tick();
    chk("t5_b3_unexp", bus.err_unexp_o, 1'b1);
    tick();
    chk("t5_pulse_1x", bus.err_unexp_o, 1'b0);

    // same-cycle AW and B keep the counter at 1
    bus.aw_hsk_i    = 1'b1;
    bus.aw_mst_id_i = 2'd1;
    tick();
    bus.aw_hsk_i = 1'b0;
    drive(2'd1, 5'd7, 2'd1);
    tick();
    bus.s_BVALID_i  = 1'b0;
    bus.aw_hsk_i    = 1'b1;
    tick();
    bus.aw_hsk_i = 1'b0;
    chk("t5_same_cyc", bus.err_unexp_o, 1'b0);
    drive(2'd1, 5'd7, 2'd1);
    tick();
    bus.s_BVALID_i = 1'b0;
    tick();
    chk("t5_last_ok",  bus.err_unexp_o, 1'b0);
    drive(2'd1, 5'd7, 2'd1);
    tick();
    bus.s_BVALID_i = 1'b0;
    tick();
    chk("t5_extra",    bus.err_unexp_o, 1'b1);
`else
    // ---- without the checker err_unexp_o never fires ----
    bus.aw_hsk_i    = 1'b1;
    bus.aw_mst_id_i = 2'd1;
    drive(2'd1, 5'd7, 2'd1);
    tick();
    bus.s_BVALID_i = 1'b0;
    bus.aw_hsk_i   = 1'b0;
    chk("t5_nochk_v",  bus.dsp_BVALID_o, 3'b010);
    tick();
    chk("t5_nochk_u1", bus.err_unexp_o,  1'b0);
    drive(2'd1, 5'd7, 2'd1);
    tick();
    bus.s_BVALID_i = 1'b0;
    tick();
    chk("t5_nochk_u2", bus.err_unexp_o,  1'b0);
`endif

    // ---- reset while the buffer holds two beats ----
    tick();
    bus.dsp_BREADY_i = 3'b000;
    drive(2'd0, 5'd1, 2'd1);
    tick();
    drive(2'd2, 5'd3, 2'd2);
    tick();
    bus.s_BVALID_i = 1'b0;
    chk("t6_full_rdy", bus.s_BREADY_o,   1'b0);
    chk("t6_full_v",   bus.dsp_BVALID_o, 3'b001);
    rstn = 1'b0;
    #1;
    chk("t6_rst_v",    bus.dsp_BVALID_o, 3'b000);
    chk("t6_rst_rdy",  bus.s_BREADY_o,   1'b0);
    chk("t6_rst_id",   bus.dsp_BID_o,    5'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("t6_rel_rdy",  bus.s_BREADY_o,   1'b1);
    chk("t6_rel_v",    bus.dsp_BVALID_o, 3'b000);
    bus.dsp_BREADY_i = 3'b111;
    tick();
    chk("t6_no_stale", bus.dsp_BVALID_o, 3'b000);
    chk("t6_badid",    bus.err_bad_id_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
